// File: rtl/unidad_carga_almacenamiento.sv
// unidad_carga_almacenamiento: load/store unit between the MEM stage and memoria_datos.
//
// It accepts one B/H/W load or store per transaction and word-aligns the address.
// Load data is sign- or zero-extended. Sub-word stores use read-modify-write,
// because memoria_datos only writes full words.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   solicitud_valida/_lista   request handshake (accepted when both are high on posedge)
//   es_escritura, funct3      operation: store/load, RISC-V width code
//   direccion_in, dato_in     byte address, store data
//   resultado, _valido        extended load data (0 for stores/errors), one-cycle pulse
//   error_acceso              qualifies the pulse: misaligned, out of range, illegal funct3
//   mem_*                     memoria_datos side (combinational read, posedge write)
//
// Optional build macro LSU_CONTADORES_EN adds the completion counters
// cuenta_cargas, cuenta_almacenamientos and cuenta_errores.
module unidad_carga_almacenamiento #(
    parameter int unsigned Ancho_Dato      = 32,
    parameter int unsigned Ancho_Direccion = 32,
    parameter int unsigned Tamanio_Mem     = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       solicitud_valida,
    output logic                       solicitud_lista,
    input  logic                       es_escritura,
    input  logic [2:0]                 funct3,
    input  logic [Ancho_Direccion-1:0] direccion_in,
    input  logic [Ancho_Dato-1:0]      dato_in,
    output logic [Ancho_Dato-1:0]      resultado,
    output logic                       resultado_valido,
    output logic                       error_acceso,
    output logic                       mem_escritura_habilitada,
    output logic                       mem_lectura_habilitada,
    output logic [Ancho_Direccion-1:0] mem_direccion,
    output logic [Ancho_Dato-1:0]      mem_dato_escritura,
    input  logic [Ancho_Dato-1:0]      mem_dato_lectura
`ifdef LSU_CONTADORES_EN
    ,
    output logic [31:0]                cuenta_cargas,
    output logic [31:0]                cuenta_almacenamientos,
    output logic [31:0]                cuenta_errores
`endif
);

    localparam logic [2:0] REPOSO    = 3'd0;
    localparam logic [2:0] LEER      = 3'd1;
    localparam logic [2:0] LEER_RMW  = 3'd2;
    localparam logic [2:0] ESCRIBIR  = 3'd3;
    localparam logic [2:0] RESPONDER = 3'd4;
    localparam logic [2:0] ERROR     = 3'd5;

    localparam logic [Ancho_Direccion-1:0] LIMITE = Ancho_Direccion'(Tamanio_Mem * 4);

    logic [2:0]                 r_estado;
    logic [2:0]                 w_estado_sig;
    logic [2:0]                 r_funct3;
    logic [Ancho_Direccion-1:0] r_direccion;
    logic [Ancho_Dato-1:0]      r_dato;
    logic [Ancho_Dato-1:0]      r_resultado;

    logic                       w_acepta;
    logic                       w_f3_legal;
    logic                       w_desalineado;
    logic                       w_error;
    logic [7:0]                 w_byte;
    logic [15:0]                w_media;
    logic [Ancho_Dato-1:0]      w_lectura_fmt;
    logic [Ancho_Dato-1:0]      w_fusion;
    logic                       w_mem_activa;

    assign solicitud_lista = (r_estado == REPOSO);
    assign w_acepta        = solicitud_valida && solicitud_lista;

    // Request legality, evaluated on the raw inputs at acceptance.
    always_comb begin
        w_f3_legal    = 1'b0;
        w_desalineado = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
            3'b100, 3'b101:         w_f3_legal = !es_escritura;
            default:                w_f3_legal = 1'b0;
        endcase
        case (funct3)
            3'b001, 3'b101: w_desalineado = direccion_in[0];
            3'b010:         w_desalineado = (direccion_in[1:0] != 2'b00);
            default:        w_desalineado = 1'b0;
        endcase
        w_error = !w_f3_legal || w_desalineado || (direccion_in >= LIMITE);
    end

    // Lane extraction and extension of the word read from memory (little-endian).
    always_comb begin
        w_byte  = mem_dato_lectura[{r_direccion[1:0], 3'b000} +: 8];
        w_media = mem_dato_lectura[{r_direccion[1], 4'b0000} +: 16];
        case (r_funct3)
            3'b000:  w_lectura_fmt = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_lectura_fmt = {{16{w_media[15]}}, w_media};
            3'b100:  w_lectura_fmt = {24'h0, w_byte};
            3'b101:  w_lectura_fmt = {16'h0, w_media};
            default: w_lectura_fmt = mem_dato_lectura;
        endcase
    end

    // Merge of the new byte/halfword into the word read during LEER_RMW.
    always_comb begin
        w_fusion = mem_dato_lectura;
        if (r_funct3 == 3'b000) begin
            w_fusion[{r_direccion[1:0], 3'b000} +: 8] = r_dato[7:0];
        end else begin
            w_fusion[{r_direccion[1], 4'b0000} +: 16] = r_dato[15:0];
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            REPOSO: begin
                if (w_acepta) begin
                    if (w_error)                 w_estado_sig = ERROR;
                    else if (!es_escritura)      w_estado_sig = LEER;
                    else if (funct3 == 3'b010)   w_estado_sig = ESCRIBIR;
                    else                         w_estado_sig = LEER_RMW;
                end
            end
            LEER:      w_estado_sig = RESPONDER;
            LEER_RMW:  w_estado_sig = ESCRIBIR;
            ESCRIBIR:  w_estado_sig = RESPONDER;
            RESPONDER: w_estado_sig = REPOSO;
            ERROR:     w_estado_sig = REPOSO;
            default:   w_estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado    <= REPOSO;
            r_funct3    <= 3'b000;
            r_direccion <= '0;
            r_dato      <= '0;
            r_resultado <= '0;
        end else begin
            r_estado <= w_estado_sig;
            case (r_estado)
                REPOSO: begin
                    if (w_acepta) begin
                        r_funct3    <= funct3;
                        r_direccion <= direccion_in;
                        r_dato      <= dato_in;
                        // An error completes next cycle with resultado = 0.
                        if (w_error) r_resultado <= '0;
                    end
                end
                LEER:     r_resultado <= w_lectura_fmt;
                LEER_RMW: r_dato      <= w_fusion;
                ESCRIBIR: r_resultado <= '0;
                default:  ;
            endcase
        end
    end

    assign w_mem_activa             = (r_estado == LEER) || (r_estado == LEER_RMW)
                                      || (r_estado == ESCRIBIR);
    assign mem_lectura_habilitada   = (r_estado == LEER) || (r_estado == LEER_RMW);
    assign mem_escritura_habilitada = (r_estado == ESCRIBIR);
    assign mem_direccion            = w_mem_activa
                                      ? {r_direccion[Ancho_Direccion-1:2], 2'b00} : '0;
    assign mem_dato_escritura       = (r_estado == ESCRIBIR) ? r_dato : '0;
    assign resultado                = r_resultado;
    assign resultado_valido         = (r_estado == RESPONDER) || (r_estado == ERROR);
    assign error_acceso             = (r_estado == ERROR);

`ifdef LSU_CONTADORES_EN
    logic r_es_escritura;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_es_escritura         <= 1'b0;
            cuenta_cargas          <= '0;
            cuenta_almacenamientos <= '0;
            cuenta_errores         <= '0;
        end else begin
            if (w_acepta) r_es_escritura <= es_escritura;
            // Counters wrap naturally at 32 bits.
            if (r_estado == RESPONDER) begin
                if (r_es_escritura) cuenta_almacenamientos <= cuenta_almacenamientos + 32'd1;
                else                cuenta_cargas          <= cuenta_cargas + 32'd1;
            end
            if (r_estado == ERROR) cuenta_errores <= cuenta_errores + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_unidad_carga_almacenamiento.sv
// Self-checking bench for unidad_carga_almacenamiento with a memoria_datos model
// and a scoreboard of expected completions.
`timescale 1ns/1ps
module tb_unidad_carga_almacenamiento;

    logic        clk = 1'b0;
    logic        rst;
    logic        solicitud_valida;
    logic        solicitud_lista;
    logic        es_escritura;
    logic [2:0]  funct3;
    logic [31:0] direccion_in;
    logic [31:0] dato_in;
    logic [31:0] resultado;
    logic        resultado_valido;
    logic        error_acceso;
    logic        mem_escritura_habilitada;
    logic        mem_lectura_habilitada;
    logic [31:0] mem_direccion;
    logic [31:0] mem_dato_escritura;
    logic [31:0] mem_dato_lectura;
`ifdef LSU_CONTADORES_EN
    logic [31:0] cuenta_cargas;
    logic [31:0] cuenta_almacenamientos;
    logic [31:0] cuenta_errores;
`endif

    always #5 clk = ~clk;

    unidad_carga_almacenamiento #(
        .Ancho_Dato      (32),
        .Ancho_Direccion (32),
        .Tamanio_Mem     (256)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .solicitud_valida         (solicitud_valida),
        .solicitud_lista          (solicitud_lista),
        .es_escritura             (es_escritura),
        .funct3                   (funct3),
        .direccion_in             (direccion_in),
        .dato_in                  (dato_in),
        .resultado                (resultado),
        .resultado_valido         (resultado_valido),
        .error_acceso             (error_acceso),
        .mem_escritura_habilitada (mem_escritura_habilitada),
        .mem_lectura_habilitada   (mem_lectura_habilitada),
        .mem_direccion            (mem_direccion),
        .mem_dato_escritura       (mem_dato_escritura),
        .mem_dato_lectura         (mem_dato_lectura)
`ifdef LSU_CONTADORES_EN
        ,
        .cuenta_cargas            (cuenta_cargas),
        .cuenta_almacenamientos   (cuenta_almacenamientos),
        .cuenta_errores           (cuenta_errores)
`endif
    );

    // memoria_datos: combinational read, posedge write, word index [9:2].
    logic [31:0] mem [256];
    assign mem_dato_lectura = mem[mem_direccion[9:2]];
    always @(posedge clk) begin
        if (mem_escritura_habilitada) mem[mem_direccion[9:2]] <= mem_dato_escritura;
    end

    typedef struct {
        logic [31:0] res;
        logic        err;
        logic        st;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] wdata;
        logic [7:0]  idx;
        int          acc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sh [256];   // reference copy of memory contents
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          acc_count = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    int          exp_loads = 0;
    int          exp_stores = 0;
    int          exp_errs = 0;
    logic [31:0] last_res = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic we, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        logic        legal;
        logic        mis;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
        e.err = !legal || mis || (a >= 32'd1024);
        e.st  = we;
        e.idx = a[9:2];
        e.acc = 0;
        w     = sh[a[9:2]];
        e.res = 32'h0; e.lat = 1; e.nrd = 0; e.nwr = 0; e.wdata = 32'h0;
        if (!e.err && !we) begin
            case (a[1:0])
                2'd0: b = w[7:0];
                2'd1: b = w[15:8];
                2'd2: b = w[23:16];
                default: b = w[31:24];
            endcase
            h = a[1] ? w[31:16] : w[15:0];
            case (f3)
                3'd0: e.res = {{24{b[7]}}, b};
                3'd1: e.res = {{16{h[15]}}, h};
                3'd4: e.res = {24'h0, b};
                3'd5: e.res = {16'h0, h};
                default: e.res = w;
            endcase
            e.lat = 2; e.nrd = 1;
        end else if (!e.err) begin
            e.nwr = 1;
            if (f3 == 3'd2) begin
                e.wdata = d; e.lat = 2;
            end else begin
                e.wdata = w; e.lat = 3; e.nrd = 1;
                if (f3 == 3'd0) begin
                    case (a[1:0])
                        2'd0: e.wdata[7:0]   = d[7:0];
                        2'd1: e.wdata[15:8]  = d[7:0];
                        2'd2: e.wdata[23:16] = d[7:0];
                        default: e.wdata[31:24] = d[7:0];
                    endcase
                end else if (a[1]) begin
                    e.wdata[31:16] = d[15:0];
                end else begin
                    e.wdata[15:0] = d[15:0];
                end
            end
        end
        return e;
    endfunction

    // Monitor: push on acceptance, pop and compare on each completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (mem_lectura_habilitada || mem_escritura_habilitada)
                check_eq("en_excl", 32'(mem_lectura_habilitada & mem_escritura_habilitada), 0);
            if (mem_lectura_habilitada) rd_seen++;
            if (mem_escritura_habilitada) begin
                wr_seen++;
                if (sb.size() > 0) begin
                    check_eq("wdata", mem_dato_escritura, sb[0].wdata);
                    check_eq("waddr", mem_direccion, {22'h0, sb[0].idx, 2'b00});
                end
            end
            if (resultado_valido) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_pulse", 32'(resultado_valido), 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("resultado", resultado, e.res);
                    check_eq("error_acceso", 32'(error_acceso), 32'(e.err));
                    check_eq("latency", 32'(cyc - e.acc), 32'(e.lat));
                    check_eq("read_cycles", 32'(rd_seen), 32'(e.nrd));
                    check_eq("write_cycles", 32'(wr_seen), 32'(e.nwr));
                    if (e.st && !e.err) sh[e.idx] = e.wdata;
                    if (e.err) exp_errs++;
                    else if (e.st) exp_stores++;
                    else exp_loads++;
                    last_res = e.res;
                end
            end
            if (solicitud_valida && solicitud_lista) begin
                e = model(es_escritura, funct3, direccion_in, dato_in);
                e.acc = cyc;
                sb.push_back(e);
                acc_count++;
                rd_seen = 0;
                wr_seen = 0;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check_eq("drain", 32'(sb.size()), 0);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] golden, input logic gold_err);
        int a0;
        @(posedge clk); #1;
        es_escritura = we; funct3 = f3; direccion_in = a; dato_in = d;
        solicitud_valida = 1'b1;
        a0 = acc_count;
        for (int i = 0; i < 20 && acc_count == a0; i++) begin
            @(posedge clk); #1;
        end
        solicitud_valida = 1'b0;
        check_eq({tag, "_accept"}, 32'(acc_count - a0), 1);
        wait_idle();
        @(posedge clk); #1;
        check_eq({tag, "_hold"}, resultado, last_res);
        check_eq({tag, "_golden"}, resultado, golden);
        check_eq({tag, "_golden_err"}, 32'(last_res == golden && sb.size() == 0), 1);
        if (gold_err) check_eq({tag, "_err_zero"}, resultado, 0);
    endtask

`ifdef LSU_CONTADORES_EN
    task automatic check_counters(input string tag);
        check_eq({tag, "_cargas"}, cuenta_cargas, 32'(exp_loads));
        check_eq({tag, "_almac"}, cuenta_almacenamientos, 32'(exp_stores));
        check_eq({tag, "_errores"}, cuenta_errores, 32'(exp_errs));
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0;
        bit seen_we;
        for (int i = 0; i < 256; i++) begin mem[i] = 32'h0; sh[i] = 32'h0; end
        rst = 1'b1; solicitud_valida = 1'b0; es_escritura = 1'b0;
        funct3 = 3'b000; direccion_in = 32'h0; dato_in = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_lista", 32'(solicitud_lista), 1);
        check_eq("rst_resultado", resultado, 0);
        check_eq("rst_valido", 32'(resultado_valido), 0);
        check_eq("rst_error", 32'(error_acceso), 0);
        check_eq("rst_en", 32'({mem_lectura_habilitada, mem_escritura_habilitada}), 0);
        check_eq("rst_dir", mem_direccion, 0);
        check_eq("rst_wdata", mem_dato_escritura, 0);
        rst = 1'b0;

        do_req("sw0",   1'b1, 3'b010, 32'h000, 32'hDEADBEEF, 32'h0, 1'b0);
        do_req("lw0",   1'b0, 3'b010, 32'h000, 32'h0, 32'hDEADBEEF, 1'b0);
        do_req("sw4",   1'b1, 3'b010, 32'h004, 32'hCAFEBABE, 32'h0, 1'b0);
        do_req("lb7",   1'b0, 3'b000, 32'h007, 32'h0, 32'hFFFFFFCA, 1'b0);
        do_req("lbu7",  1'b0, 3'b100, 32'h007, 32'h0, 32'h000000CA, 1'b0);
        do_req("lh4",   1'b0, 3'b001, 32'h004, 32'h0, 32'hFFFFBABE, 1'b0);
        do_req("lhu6",  1'b0, 3'b101, 32'h006, 32'h0, 32'h0000CAFE, 1'b0);
        do_req("sw10",  1'b1, 3'b010, 32'h010, 32'h12345678, 32'h0, 1'b0);
        do_req("sb11",  1'b1, 3'b000, 32'h011, 32'h000000AB, 32'h0, 1'b0);
        do_req("lw10a", 1'b0, 3'b010, 32'h010, 32'h0, 32'h1234AB78, 1'b0);
        do_req("sh12",  1'b1, 3'b001, 32'h012, 32'h00009999, 32'h0, 1'b0);
        do_req("lw10b", 1'b0, 3'b010, 32'h010, 32'h0, 32'h9999AB78, 1'b0);
        do_req("sw3fc", 1'b1, 3'b010, 32'h3FC, 32'hABCDEF01, 32'h0, 1'b0);
        do_req("lw3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'hABCDEF01, 1'b0);
        check_eq("mem255", mem[255], 32'hABCDEF01);
        do_req("lw400", 1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1);
        do_req("lw002", 1'b0, 3'b010, 32'h002, 32'h0, 32'h0, 1'b1);
        do_req("lh001", 1'b0, 3'b001, 32'h001, 32'h0, 32'h0, 1'b1);
        do_req("sbu",   1'b1, 3'b100, 32'h008, 32'h11, 32'h0, 1'b1);
        do_req("lf3_3", 1'b0, 3'b011, 32'h008, 32'h0, 32'h0, 1'b1);

        // Valid held for nine cycles: a load takes three, so exactly three acceptances.
        @(posedge clk); #1;
        es_escritura = 1'b0; funct3 = 3'b010; direccion_in = 32'h004;
        a0 = acc_count;
        solicitud_valida = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        solicitud_valida = 1'b0;
        wait_idle();
        check_eq("held_accepts", 32'(acc_count - a0), 3);
        check_eq("held_result", resultado, 32'hCAFEBABE);
`ifdef LSU_CONTADORES_EN
        check_counters("cnt");
`endif

        // Reset while the sub-word store is in ESCRIBIR: the write must be dropped.
        @(posedge clk); #1;
        es_escritura = 1'b1; funct3 = 3'b000; direccion_in = 32'h011; dato_in = 32'h55;
        a0 = acc_count;
        solicitud_valida = 1'b1;
        for (int i = 0; i < 20 && acc_count == a0; i++) begin
            @(posedge clk); #1;
        end
        solicitud_valida = 1'b0;
        seen_we = 1'b0;
        for (int i = 0; i < 10 && !seen_we; i++) begin
            @(negedge clk);
            if (mem_escritura_habilitada) seen_we = 1'b1;
        end
        rst = 1'b1;
        #1;
        check_eq("rst_saw_write", 32'(seen_we), 1);
        check_eq("rst_we_drop", 32'(mem_escritura_habilitada), 0);
        sb.delete();
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_lista_after", 32'(solicitud_lista), 1);
        check_eq("rst_no_pulse", 32'(resultado_valido), 0);
        check_eq("rst_word_kept", mem[4], 32'h9999AB78);
`ifdef LSU_CONTADORES_EN
        check_counters("cnt_rst");
`endif
        do_req("lw10c", 1'b0, 3'b010, 32'h010, 32'h0, 32'h9999AB78, 1'b0);
`ifdef LSU_CONTADORES_EN
        check_counters("cnt_end");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
